// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
// One result bit per cycle; magnitudes are iterated unsigned and the sign is applied in FIX.
module mul_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               res_neg;
  logic               rem_neg;
  logic               div_op;

  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    accept    = (state == S_IDLE) && start && !flush;
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    signed_op = SIGNED_EN && ((op == OP_MULT) || (op == OP_DIV));
    a_neg     = signed_op && operand_a[WIDTH-1];
    b_neg     = signed_op && operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
    b_zero    = (operand_b == '0);
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; the remainder fits WIDTH bits after restore.
  always_comb begin
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_shift[WIDTH-1:0] - (div_ge ? b_q : '0);
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quot_fix = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)                 next_state = S_MUL;
        else if (accept && is_div && !b_zero) next_state = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)            next_state = S_IDLE;
        else if (cnt == '0)   next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    stall_req = busy && start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      div_op      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (is_mul || (is_div && !b_zero))) begin
            acc     <= {{WIDTH{1'b0}}, a_mag};
            b_q     <= b_mag;
            cnt     <= CW'(WIDTH - 1);
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            div_op  <= is_div;
          end else if (accept && is_div) begin
            lo          <= '1;
            hi          <= operand_a;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end else if (accept && op == OP_MTHI) begin
            hi   <= operand_a;
            done <= 1'b1;
          end else if (accept && op == OP_MTLO) begin
            lo   <= operand_a;
            done <= 1'b1;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            if (div_op) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int stall_bad;
  int done_seen;

  mul_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (opa),
    .operand_b   (opb),
    .flush       (flush),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    opa   = x;
    opb   = y;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000; opa = '0; opb = '0; flush = 1'b0;
    repeat (2) step();
    check("rst_hi",   64'(hi),          64'(0));
    check("rst_lo",   64'(lo),          64'(0));
    check("rst_busy", 64'(busy),        64'(0));
    check("rst_done", 64'(done),        64'(0));
    check("rst_dbz",  64'(div_by_zero), 64'(0));
    reset = 1'b1;
    step();

    start = 1'b1; op = OP_MULTU; opa = 32'hFFFF_FFFF; opb = 32'h2;
    check("stall_idle", 64'(stall_req), 64'(0));
    step();
    start = 1'b0;
    wait_idle(cyc);
    check("multu_busy_cycles", 64'(cyc),  64'(33));
    check("multu_hi",          64'(hi),   64'h0000_0001);
    check("multu_lo",          64'(lo),   64'hFFFF_FFFE);
    check("multu_done",        64'(done), 64'(1));
    step();
    check("multu_done_pulse",  64'(done), 64'(0));

    go(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    repeat (5) step();
    check("hold_hi", 64'(hi), 64'h0000_0001);
    check("hold_lo", 64'(lo), 64'hFFFF_FFFE);
    wait_idle(cyc);
    check("mult_hi",   64'(hi),   64'hFFFF_FFFF);
    check("mult_lo",   64'(lo),   64'hFFFF_FFD6);
    check("mult_done", 64'(done), 64'(1));

    go(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    go(OP_DIVU, 32'd100, 32'd0);
    check("dbz_busy", 64'(busy),        64'(0));
    check("dbz_done", 64'(done),        64'(1));
    check("dbz_flag", 64'(div_by_zero), 64'(1));
    check("dbz_lo",   64'(lo),          64'hFFFF_FFFF);
    check("dbz_hi",   64'(hi),          64'd100);
    step();
    check("dbz_done_pulse", 64'(done),        64'(0));
    check("dbz_flag_pulse", 64'(div_by_zero), 64'(0));

    go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("ovf_lo",   64'(lo),          64'h8000_0000);
    check("ovf_hi",   64'(hi),          64'(0));
    check("ovf_done", 64'(done),        64'(1));
    check("ovf_dbz",  64'(div_by_zero), 64'(0));

    go(OP_MULT, 32'd3, 32'd5);
    start = 1'b1; op = OP_DIVU; opa = 32'd10; opb = 32'd3;
    stall_bad = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall_req !== 1'b1) stall_bad++;
      cyc++;
      step();
    end
    check("b2b_stall_bad",  64'(stall_bad), 64'(0));
    check("b2b_busy_cyc",   64'(cyc),       64'(33));
    check("b2b_stall_fall", 64'(stall_req), 64'(0));
    check("b2b_mult_done",  64'(done),      64'(1));
    check("b2b_mult_lo",    64'(lo),        64'd15);
    check("b2b_mult_hi",    64'(hi),        64'(0));
    step();
    start = 1'b0;
    check("b2b_divu_busy", 64'(busy), 64'(1));
    wait_idle(cyc);
    check("b2b_divu_lo", 64'(lo), 64'd3);
    check("b2b_divu_hi", 64'(hi), 64'd1);

    go(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi",   64'(hi),   64'h1234);
    check("mthi_done", 64'(done), 64'(1));
    check("mthi_busy", 64'(busy), 64'(0));
    go(OP_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo",   64'(lo),   64'h5678);

    go(OP_MULT, 32'd7, 32'd9);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi",   64'(hi),   64'h1234);
    check("flush_lo",   64'(lo),   64'h5678);
    check("flush_done", 64'(done), 64'(0));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    check("flush_no_done", 64'(done_seen), 64'(0));

    start = 1'b1; op = OP_MTLO; opa = 32'h9999; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_lo",   64'(lo),   64'h5678);
    check("flush_start_done", 64'(done), 64'(0));

    go(3'b110, 32'd1, 32'd1);
    check("op6_busy", 64'(busy), 64'(0));
    check("op6_done", 64'(done), 64'(0));
    check("op6_hi",   64'(hi),   64'h1234);

    go(OP_DIV, 32'd100, 32'd7);
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_hi",   64'(hi),   64'(0));
    check("arst_lo",   64'(lo),   64'(0));
    check("arst_done", 64'(done), 64'(0));
    step();
    reset = 1'b1;
    step();
    go(OP_MTLO, 32'hAB, 32'd0);
    check("post_rst_lo",   64'(lo),   64'hAB);
    check("post_rst_done", 64'(done), 64'(1));
    step();
    check("post_rst_done_pulse", 64'(done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
